// File: rtl/mux_nx1_reg.sv
// N-to-1 valid/ready multiplexer with a single registered output stage and
// fixed-select or round-robin arbitration. Define MUX_NX1_CHAN_OUT_EN to add out_chan.
module mux_nx1_reg #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_NX1_CHAN_OUT_EN
  ,
  output logic [SEL_W-1:0]          out_chan
`endif
);

  logic [WIDTH-1:0]    r_data;
  logic                r_valid;
  logic [SEL_W-1:0]    r_ptr;

  logic                w_load_en;
  logic                w_grant_vld;
  logic [SEL_W-1:0]    w_grant_idx;
  logic [SEL_W-1:0]    w_ptr_next;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_in_xfer;
  logic [CHANNELS-1:0] w_in_ready;
  int                  w_idx;

  assign w_load_en = ~r_valid | out_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx       = 0;
    if (!mode) begin
      if (int'(sel) < CHANNELS) begin
        w_grant_vld = 1'b1;
        w_grant_idx = sel;
      end
    end else begin
      // Search upward from ptr, wrapping at CHANNELS rather than at 2**SEL_W.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        w_idx = int'(r_ptr) + i;
        if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
        if (in_valid[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SEL_W'(w_idx);
        end
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    w_sel_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_in_ready[k] = rst_n & w_load_en & w_grant_vld & (w_grant_idx == SEL_W'(k));
      if (w_grant_idx == SEL_W'(k)) w_sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_in_xfer  = |(w_in_ready & in_valid);
  assign w_ptr_next = (w_grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_grant_idx + SEL_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ptr   <= '0;
    end else if (w_in_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_sel_data;
      r_ptr   <= w_ptr_next;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUX_NX1_CHAN_OUT_EN
  logic [SEL_W-1:0] r_chan;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chan <= '0;
    end else if (w_in_xfer) begin
      r_chan <= w_grant_idx;
    end
  end

  assign out_chan = r_chan;
`else
`endif

  assign in_ready  = w_in_ready;
  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Directed table-driven bench for mux_nx1_reg (WIDTH=8, CHANNELS=8), with
// hand-written back-pressure and mid-stream reset sequences.
module tb_mux_nx1_reg;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
`ifdef MUX_NX1_CHAN_OUT_EN
  logic [SEL_W-1:0]          out_chan;
`endif

  mux_nx1_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_NX1_CHAN_OUT_EN
    ,
    .out_chan  (out_chan)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic [7:0]       iv;
    logic             ordy;
    logic [7:0]       exp_rdy;
    logic             exp_ov;
    logic [7:0]       exp_od;
    logic [SEL_W-1:0] exp_chan;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [SEL_W-1:0] s, input logic [7:0] iv,
                              input logic ordy, input logic [7:0] rdy, input logic ov,
                              input logic [7:0] od, input logic [SEL_W-1:0] ch);
    vec_t v;
    v.mode = m; v.sel = s; v.iv = iv; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_od = od; v.exp_chan = ch;
    return v;
  endfunction

  // Compare in_ready before the edge, registered outputs just after it.
  task automatic cycle(input string name, input logic [7:0] rdy, input logic ov,
                       input logic [7:0] od, input logic [SEL_W-1:0] ch);
    #1;
    check({name, " in_ready"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    check({name, " out_valid"}, 32'(out_valid), 32'(ov));
    check({name, " out_data"}, 32'(out_data), 32'(od));
`ifdef MUX_NX1_CHAN_OUT_EN
    check({name, " out_chan"}, 32'(out_chan), 32'(ch));
`else
    if (ch === 'x) $display("unused channel expectation");
`endif
  endtask

  initial begin
    for (int k = 0; k < CHANNELS; k++) in_data[k*WIDTH +: WIDTH] = 8'(8'h10 + k);
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 3'd5;
    in_valid  = 8'hFF;
    out_ready = 1'b1;

    // Fixed mode, sel=5, then channel 5 drops valid and the register drains.
    vecs.push_back(mk(0, 5, 8'hFF, 1, 8'h20, 1, 8'h15, 5));
    vecs.push_back(mk(0, 5, 8'hFF, 1, 8'h20, 1, 8'h15, 5));
    vecs.push_back(mk(0, 5, 8'hFF, 1, 8'h20, 1, 8'h15, 5));
    vecs.push_back(mk(0, 5, 8'hDF, 1, 8'h20, 0, 8'h15, 5));
    vecs.push_back(mk(0, 5, 8'hDF, 1, 8'h20, 0, 8'h15, 5));
    // Empty register accepts despite out_ready=0, then blocks.
    vecs.push_back(mk(0, 3, 8'hFF, 0, 8'h08, 1, 8'h13, 3));
    vecs.push_back(mk(0, 3, 8'hFF, 0, 8'h00, 1, 8'h13, 3));
    vecs.push_back(mk(0, 7, 8'hFF, 1, 8'h80, 1, 8'h17, 7));
    // Round-robin, all valid, starting from ptr=0 (left by the sel=7 accept).
    for (int k = 0; k <= CHANNELS; k++) begin
      int c;
      c = k % CHANNELS;
      vecs.push_back(mk(1, 0, 8'hFF, 1, 8'(1 << c), 1, 8'(8'h10 + c), SEL_W'(c)));
    end
    // Set ptr=2 through a fixed accept on channel 1, then wrap over channels 7 and 1.
    vecs.push_back(mk(0, 1, 8'hFF, 1, 8'h02, 1, 8'h11, 1));
    vecs.push_back(mk(1, 0, 8'h82, 1, 8'h80, 1, 8'h17, 7));
    vecs.push_back(mk(1, 0, 8'h82, 1, 8'h02, 1, 8'h11, 1));
    vecs.push_back(mk(1, 0, 8'h82, 1, 8'h80, 1, 8'h17, 7));

    // Reset state, with in_ready forced low while rst_n=0.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      mode      = vecs[i].mode;
      sel       = vecs[i].sel;
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      cycle($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ov,
            vecs[i].exp_od, vecs[i].exp_chan);
    end

    // Back-pressure: holding 8'h17 with ptr=0; three stalled cycles.
    mode     = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle($sformatf("stall%0d", i), 8'h00, 1, 8'h17, 7);
    out_ready = 1'b1;
    cycle("release0", 8'h01, 1, 8'h10, 0);
    cycle("release1", 8'h02, 1, 8'h11, 1);

    // ptr=2 with channels 1 and 3 valid: next grant is 3 unless reset intervenes.
    in_valid = 8'b0000_1010;
    #1;
    check("pre-reset grant", 32'(in_ready), 32'h08);
    rst_n = 1'b0;
    cycle("reset mid", 8'h00, 0, 8'h00, 0);
    rst_n = 1'b1;
    cycle("post-reset grant", 8'h02, 1, 8'h11, 1);
    in_valid = 8'h00;
    cycle("drain", 8'h00, 0, 8'h11, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
